// File: rtl/dmi_boot_pkg.sv
// Shared types and helpers for the DMI boot sequencer.
// Encodes the fixed debug-module request list used to start a hart.
package dmi_boot_pkg;

    // Debug module register addresses on the DMI bus
    localparam logic [6:0] DMI_DATA0      = 7'h04;
    localparam logic [6:0] DMI_DMCONTROL  = 7'h10;
    localparam logic [6:0] DMI_DMSTATUS   = 7'h11;
    localparam logic [6:0] DMI_ABSTRACTCS = 7'h16;
    localparam logic [6:0] DMI_COMMAND    = 7'h17;

    // DMI operation encodings
    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    // DMI response encodings
    localparam logic [1:0] DMI_RESP_OK       = 2'd0;
    localparam logic [1:0] DMI_RESP_RESERVED = 2'd1;
    localparam logic [1:0] DMI_RESP_FAILED   = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY     = 2'd3;

    localparam logic [11:0] CSR_DPC = 12'h7B1;

    // dmcontrol / dmstatus / abstractcs bit positions
    localparam int unsigned DMCTRL_HALTREQ   = 31;
    localparam int unsigned DMCTRL_RESUMEREQ = 30;
    localparam int unsigned DMSTAT_ALLHALTED = 9;
    localparam int unsigned DMSTAT_ALLRESUME = 17;
    localparam int unsigned ACS_BUSY         = 12;

    typedef enum logic [3:0] {
        STEP_ACTIVATE    = 4'd0,
        STEP_SELECT      = 4'd1,
        STEP_HALTREQ     = 4'd2,
        STEP_WAIT_HALT   = 4'd3,
        STEP_CLR_HALT    = 4'd4,
        STEP_DATA0       = 4'd5,
        STEP_COMMAND     = 4'd6,
        STEP_WAIT_CMD    = 4'd7,
        STEP_RESUMEREQ   = 4'd8,
        STEP_WAIT_RESUME = 4'd9,
        STEP_CLR_RESUME  = 4'd10
    } step_e;

    localparam int unsigned NUM_STEPS = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    // Abstract command: access register, aarsize=2, transfer, write, regno
    function automatic logic [31:0] access_reg_write(input logic [11:0] regno);
        logic [31:0] cmd;
        cmd        = '0;
        cmd[22:20] = 3'd2;
        cmd[17]    = 1'b1;
        cmd[16]    = 1'b1;
        cmd[11:0]  = regno;
        return cmd;
    endfunction

    // Request issued for a given step
    function automatic dmi_req_t step_req(input step_e step,
                                          input logic [9:0] hartsel,
                                          input logic [31:0] boot_addr);
        dmi_req_t    req;
        logic [31:0] sel;
        sel       = {6'd0, hartsel, 15'd0, 1'b1};
        req.addr  = DMI_DMCONTROL;
        req.op    = DMI_OP_WRITE;
        req.data  = sel;
        unique case (step)
            STEP_ACTIVATE: req.data = 32'h1;
            STEP_SELECT: req.data = sel;
            STEP_HALTREQ: req.data[DMCTRL_HALTREQ] = 1'b1;
            STEP_WAIT_HALT: begin
                req.addr = DMI_DMSTATUS;
                req.op   = DMI_OP_READ;
                req.data = '0;
            end
            STEP_CLR_HALT: req.data = sel;
            STEP_DATA0: begin
                req.addr = DMI_DATA0;
                req.data = boot_addr;
            end
            STEP_COMMAND: begin
                req.addr = DMI_COMMAND;
                req.data = access_reg_write(CSR_DPC);
            end
            STEP_WAIT_CMD: begin
                req.addr = DMI_ABSTRACTCS;
                req.op   = DMI_OP_READ;
                req.data = '0;
            end
            STEP_RESUMEREQ: req.data[DMCTRL_RESUMEREQ] = 1'b1;
            STEP_WAIT_RESUME: begin
                req.addr = DMI_DMSTATUS;
                req.op   = DMI_OP_READ;
                req.data = '0;
            end
            STEP_CLR_RESUME: req.data = sel;
            default: req = '0;
        endcase
        return req;
    endfunction

    // Poll-exit condition for read steps
    function automatic logic poll_met(input step_e step,
                                      input logic [31:0] rdata);
        logic met;
        unique case (step)
            STEP_WAIT_HALT:   met = rdata[DMSTAT_ALLHALTED];
            STEP_WAIT_CMD:    met = ~rdata[ACS_BUSY];
            STEP_WAIT_RESUME: met = rdata[DMSTAT_ALLRESUME];
            default:          met = 1'b1;
        endcase
        return met;
    endfunction

    // Abstract command finished but reported cmderr
    function automatic logic cmd_failed(input step_e step,
                                        input logic [31:0] rdata);
        return (step == STEP_WAIT_CMD) && !rdata[ACS_BUSY]
            && (rdata[10:8] != 3'd0);
    endfunction

endpackage

// File: rtl/dmi_boot_sequencer.sv
// DMI master that halts a hart, writes DPC and resumes it.
// Replaces the JTAG boot sequence so a preloaded image starts by itself.
module dmi_boot_sequencer
    import dmi_boot_pkg::*;
#(
    parameter logic [9:0]  HartSel        = 10'd0,
    parameter int unsigned PollLimit      = 1024,
    parameter int unsigned BusyRetryLimit = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] boot_addr_i,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [6:0]  dmi_req_addr_o,
    output logic [1:0]  dmi_req_op_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [3:0]  err_step_o
);

    localparam int unsigned PollW = $clog2(PollLimit + 1);
    localparam int unsigned BusyW = $clog2(BusyRetryLimit + 1);

    // Counter values at which one more event hits the limit
    localparam logic [PollW-1:0] PollMax = PollW'(PollLimit - 1);
    localparam logic [BusyW-1:0] BusyMax = BusyW'(BusyRetryLimit - 1);

    state_e           state_q, state_d;
    step_e            step_q, step_d;
    logic [31:0]      addr_q, addr_d;
    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
    logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
    dmi_req_t         req;
    logic             is_write;

    assign req      = step_req(step_q, HartSel, addr_q);
    assign is_write = (req.op == DMI_OP_WRITE);

    // State, step, latched address and retry counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_ACTIVATE;
            addr_q     <= '0;
            poll_cnt_q <= '0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            addr_q     <= addr_d;
            poll_cnt_q <= poll_cnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Next-state: request handshake, response decode, retries and polls
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        addr_d     = addr_q;
        poll_cnt_d = poll_cnt_q;
        busy_cnt_d = busy_cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d    = ST_REQ;
                    step_d     = STEP_ACTIVATE;
                    addr_d     = boot_addr_i;
                    poll_cnt_d = '0;
                    busy_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (dmi_req_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (dmi_resp_valid_i) begin
                    unique case (dmi_resp_resp_i)
                        DMI_RESP_OK: begin
                            if (cmd_failed(step_q, dmi_resp_data_i)) begin
                                state_d = ST_ERROR;
                            end else if (is_write ||
                                         poll_met(step_q, dmi_resp_data_i)) begin
                                poll_cnt_d = '0;
                                busy_cnt_d = '0;
                                if (step_q == STEP_CLR_RESUME) begin
                                    state_d = ST_DONE;
                                end else begin
                                    state_d = ST_REQ;
                                    step_d  = step_e'(4'(step_q) + 4'd1);
                                end
                            end else if (poll_cnt_q == PollMax) begin
                                state_d = ST_ERROR;
                            end else begin
                                state_d    = ST_REQ;
                                poll_cnt_d = poll_cnt_q + PollW'(1);
                                busy_cnt_d = '0;
                            end
                        end
                        DMI_RESP_BUSY: begin
                            if (busy_cnt_q == BusyMax) begin
                                state_d = ST_ERROR;
                            end else begin
                                state_d    = ST_REQ;
                                busy_cnt_d = busy_cnt_q + BusyW'(1);
                            end
                        end
                        default: state_d = ST_ERROR;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are pure decodes of the registered state
    always_comb begin
        dmi_req_valid_o  = (state_q == ST_REQ);
        dmi_req_addr_o   = '0;
        dmi_req_op_o     = DMI_OP_NOP;
        dmi_req_data_o   = '0;
        dmi_resp_ready_o = (state_q == ST_RESP);
        busy_o           = (state_q == ST_REQ) || (state_q == ST_RESP);
        done_o           = (state_q == ST_DONE);
        error_o          = (state_q == ST_ERROR);
        err_step_o       = '0;
        if (dmi_req_valid_o) begin
            dmi_req_addr_o = req.addr;
            dmi_req_op_o   = req.op;
            dmi_req_data_o = is_write ? req.data : 32'h0;
        end
        if (error_o) begin
            err_step_o = 4'(step_q);
        end
    end

endmodule

// File: tb/tb_dmi_boot_sequencer.sv
// Directed bench for dmi_boot_sequencer against a small DM model.
// Checks request order, stalls, busy retries, polls, errors and reset.
module tb_dmi_boot_sequencer;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] boot_addr_i;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [6:0]  dmi_req_addr_o;
    logic [1:0]  dmi_req_op_o;
    logic [31:0] dmi_req_data_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i;
    logic [1:0]  dmi_resp_resp_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [3:0]  err_step_o;

    localparam logic [31:0] HS  = 32'h0005_0000;
    localparam logic [31:0] CMD = 32'h0023_07B1;

    dmi_boot_sequencer #(.HartSel(10'd5)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .boot_addr_i      (boot_addr_i),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_resp_i  (dmi_resp_resp_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .err_step_o       (err_step_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // DM model configuration
    int          halt_cfg   = 0;
    int          busy_cfg   = 0;
    int          hold_cfg   = 0;
    logic [2:0]  cmderr_cfg = 3'd0;
    logic        model_clr  = 1'b0;
    logic [31:0] cur_boot   = '0;

    // DM model state
    logic        pending;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          stall_q, halt_q, busy_q, unstable;
    logic [6:0]  log_a[$];
    logic [1:0]  log_o[$];
    logic [31:0] log_d[$];

    assign dmi_req_ready_i = !(dmi_req_valid_o && dmi_req_addr_o == 7'h04
                               && stall_q < hold_cfg);
    assign dmi_resp_valid_i = pending;
    assign dmi_resp_data_i  = rdata;
    assign dmi_resp_resp_i  = rresp;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
        end else if (model_clr) begin
            pending  <= 1'b0;
            stall_q  <= 0;
            halt_q   <= 0;
            busy_q   <= 0;
            unstable <= 0;
        end else begin
            if (dmi_req_valid_o && !dmi_req_ready_i) begin
                stall_q <= stall_q + 1;
                if (dmi_req_addr_o != 7'h04 || dmi_req_op_o != 2'd2
                    || dmi_req_data_o != cur_boot)
                    unstable <= unstable + 1;
            end
            if (dmi_req_valid_o && dmi_req_ready_i) begin
                log_a.push_back(dmi_req_addr_o);
                log_o.push_back(dmi_req_op_o);
                log_d.push_back(dmi_req_data_o);
                pending <= 1'b1;
                rdata   <= '0;
                rresp   <= 2'd0;
                case (dmi_req_addr_o)
                    7'h11: begin
                        if (halt_q < halt_cfg) halt_q <= halt_q + 1;
                        else rdata <= (32'h1 << 9) | (32'h1 << 17);
                    end
                    7'h16: rdata <= {21'd0, cmderr_cfg, 8'd0};
                    7'h17: begin
                        if (busy_q < busy_cfg) begin
                            busy_q <= busy_q + 1;
                            rresp  <= 2'd3;
                        end
                    end
                    default: ;
                endcase
            end else if (pending && dmi_resp_ready_o) begin
                pending <= 1'b0;
            end
        end
    end

    function automatic int count_req(input logic [6:0] a, input logic [1:0] o);
        int n = 0;
        foreach (log_a[i]) if (log_a[i] == a && log_o[i] == o) n++;
        return n;
    endfunction

    function automatic logic [31:0] find_data(input logic [6:0] a);
        foreach (log_a[i]) if (log_a[i] == a) return log_d[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Start a sequence and wait for done/error; optional start glitch
    task automatic run(input logic [31:0] boot, input int glitch_at,
                       output int cyc);
        log_a.delete();
        log_o.delete();
        log_d.delete();
        cur_boot = boot;
        @(negedge clk);
        model_clr = 1'b1;
        @(negedge clk);
        model_clr   = 1'b0;
        start_i     = 1'b1;
        boot_addr_i = boot;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        boot_addr_i = 32'hDEAD_BEE0;
        cyc = 0;
        while (!(done_o || error_o) && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            start_i = (cyc == glitch_at);
        end
        start_i = 1'b0;
        check("finished", {31'd0, done_o | error_o}, 32'd1);
    endtask

    task automatic check_seq(input logic [31:0] boot);
        logic [6:0]  ea[11];
        logic [1:0]  eo[11];
        logic [31:0] ed[11];
        ea = '{7'h10, 7'h10, 7'h10, 7'h11, 7'h10, 7'h04,
               7'h17, 7'h16, 7'h10, 7'h11, 7'h10};
        eo = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2,
               2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        ed = '{32'h1, HS | 32'h1, 32'h8000_0000 | HS | 32'h1, 32'h0,
               HS | 32'h1, boot, CMD, 32'h0,
               32'h4000_0000 | HS | 32'h1, 32'h0, HS | 32'h1};
        check("seq_len", log_a.size(), 11);
        if (log_a.size() == 11) begin
            for (int i = 0; i < 11; i++) begin
                check($sformatf("seq_addr[%0d]", i), {25'd0, log_a[i]}, {25'd0, ea[i]});
                check($sformatf("seq_op[%0d]", i), {30'd0, log_o[i]}, {30'd0, eo[i]});
                check($sformatf("seq_data[%0d]", i), log_d[i], ed[i]);
            end
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_valid"}, {31'd0, dmi_req_valid_o}, 0);
        check({tag, "_addr"}, {25'd0, dmi_req_addr_o}, 0);
        check({tag, "_op"}, {30'd0, dmi_req_op_o}, 0);
        check({tag, "_data"}, dmi_req_data_o, 0);
        check({tag, "_rready"}, {31'd0, dmi_resp_ready_o}, 0);
        check({tag, "_busy"}, {31'd0, busy_o}, 0);
        check({tag, "_done"}, {31'd0, done_o}, 0);
        check({tag, "_error"}, {31'd0, error_o}, 0);
        check({tag, "_errstep"}, {28'd0, err_step_o}, 0);
    endtask

    initial begin
        int cyc;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        boot_addr_i = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst_ni = 1'b1;
        @(negedge clk);
        check_reset_outs("idle");

        // Ideal DM
        run(32'h8000_0080, -1, cyc);
        check("ideal_cycles", cyc, 22);
        check("ideal_done", {31'd0, done_o}, 1);
        check("ideal_error", {31'd0, error_o}, 0);
        check("ideal_busy", {31'd0, busy_o}, 0);
        check_seq(32'h8000_0080);
        @(negedge clk);
        check("done_sticky", {31'd0, done_o}, 1);

        // allhalted late by 5 reads, plus an ignored start mid-run
        halt_cfg = 5;
        run(32'h8000_0200, 3, cyc);
        halt_cfg = 0;
        check("poll_done", {31'd0, done_o}, 1);
        check("poll_dmstatus_reads", count_req(7'h11, 2'd1), 7);
        check("poll_total", log_a.size(), 16);
        check("ignored_start_data0", find_data(7'h04), 32'h8000_0200);

        // DM stalls data0 write for 7 cycles
        hold_cfg = 7;
        run(32'h8000_0300, -1, cyc);
        check("stall_cycles", stall_q, 7);
        check("stall_unstable", unstable, 0);
        check("stall_one_xfer", count_req(7'h04, 2'd2), 1);
        check("stall_done", {31'd0, done_o}, 1);
        hold_cfg = 0;

        // Two busy responses on command then ok
        busy_cfg = 2;
        run(32'h8000_0400, -1, cyc);
        check("busy2_cmd_reqs", count_req(7'h17, 2'd2), 3);
        check("busy2_done", {31'd0, done_o}, 1);
        check("busy2_error", {31'd0, error_o}, 0);

        // Busy forever on command -> error at step 6
        busy_cfg = 100;
        run(32'h8000_0500, -1, cyc);
        busy_cfg = 0;
        check("busy16_error", {31'd0, error_o}, 1);
        check("busy16_errstep", {28'd0, err_step_o}, 6);
        check("busy16_cmd_reqs", count_req(7'h17, 2'd2), 16);
        check("busy16_done", {31'd0, done_o}, 0);
        check("busy16_busy", {31'd0, busy_o}, 0);

        // cmderr reported -> error at step 7, no resumereq
        cmderr_cfg = 3'b010;
        run(32'h8000_0600, -1, cyc);
        cmderr_cfg = 3'd0;
        check("cmderr_error", {31'd0, error_o}, 1);
        check("cmderr_errstep", {28'd0, err_step_o}, 7);
        check("cmderr_no_resume", {31'd0, (log_a.size() > 0) &&
              (log_d[log_d.size()-1][30] == 1'b1)}, 0);
        check("cmderr_last_addr", {25'd0, log_a[log_a.size()-1]}, 32'h16);

        // Reset while waiting for the step 4 response
        log_a.delete();
        log_o.delete();
        log_d.delete();
        @(negedge clk);
        start_i     = 1'b1;
        boot_addr_i = 32'h8000_0700;
        @(negedge clk);
        start_i = 1'b0;
        check("restart_clears_error", {31'd0, error_o}, 0);
        cyc = 0;
        while (log_a.size() < 5 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid_reached_step4", log_a.size(), 5);
        check("mid_in_resp", {31'd0, dmi_resp_ready_o}, 1);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(negedge clk);
        check_reset_outs("midrst2");
        rst_ni = 1'b1;
        run(32'h8000_1000, -1, cyc);
        check("after_rst_cycles", cyc, 22);
        check_seq(32'h8000_1000);
        check("after_rst_done", {31'd0, done_o}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
